cpu_core_p: RTL

Parametrised successor to the 8-bit two-word-instruction CPU top. It keeps the same five-stage sequencer (await/fetcha/fetchb/execa/execb), PC, register file and opcode/operand latches. New relative to that CPU:
- data width, address width and register count are generalised;
- memory sits outside the core behind a ready handshake, so wait states are supported;
- ST/STS, ALU ops with flags, jumps, and HLT/halt-at-boundary are added.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/regfile_p.sv | 39 +++
 rtl/cpu_core_p.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised two-word-instruction CPU core.
package cpu_pkg;

  // Opcode field values (top five bits of instruction word 1).
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_MOV = 5'b00001;
  localparam logic [4:0] OP_LD  = 5'b01000;
  localparam logic [4:0] OP_LDS = 5'b01001;
  localparam logic [4:0] OP_LDI = 5'b01010;
  localparam logic [4:0] OP_ST  = 5'b01100;
  localparam logic [4:0] OP_STS = 5'b01101;
  localparam logic [4:0] OP_ADD = 5'b10000;
  localparam logic [4:0] OP_SUB = 5'b10001;
  localparam logic [4:0] OP_AND = 5'b10010;
  localparam logic [4:0] OP_OR  = 5'b10011;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_JZ  = 5'b11001;
  localparam logic [4:0] OP_JC  = 5'b11010;
  localparam logic [4:0] OP_HLT = 5'b11111;

  // Bit positions of each sequencer stage in the one-hot stage vector.
  localparam int STG_AWAIT  = 0;
  localparam int STG_FETCHA = 1;
  localparam int STG_FETCHB = 2;
  localparam int STG_EXECA  = 3;
  localparam int STG_EXECB  = 4;

  typedef enum logic [4:0] {
    S_AWAIT  = 5'(1 << STG_AWAIT),
    S_FETCHA = 5'(1 << STG_FETCHA),
    S_FETCHB = 5'(1 << STG_FETCHB),
    S_EXECA  = 5'(1 << STG_EXECA),
    S_EXECB  = 5'(1 << STG_EXECB)
  } stage_e;

  // Width of a register-select field for a file of n registers.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_p.sv
// General register file: three combinational read ports, one synchronous write port.
module regfile_p
  import cpu_pkg::*;
#(
  parameter int REG_N  = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  rd_a_sel_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [SEL_W-1:0]  rd_c_sel_i,
  output logic [DATA_W-1:0] rd_c_data_o,
  input  logic [SEL_W-1:0]  rd_d_sel_i,
  output logic [DATA_W-1:0] rd_d_data_o,
  input  logic              we_i,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // Register storage with asynchronous clear and one write per cycle.
  // NOTE: the array is built from flops, not a RAM macro, so clearing every entry on reset is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wr_sel_i] <= wr_data_i;
    end
  end

  // Reads see the pre-write value when a port addresses the register being written.
  assign rd_a_data_o = regs_q[rd_a_sel_i];
  assign rd_c_data_o = regs_q[rd_c_sel_i];
  assign rd_d_data_o = regs_q[rd_d_sel_i];

endmodule

// File: rtl/cpu_core_p.sv
// Five-stage sequenced CPU core with external memory behind a ready handshake.
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                REG_N    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        halt,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           pc,
  output logic [DATA_W-1:0]           opcode,
  output logic [DATA_W-1:0]           operand,
  output logic [4:0]                  stage,
  output logic                        cflag,
  output logic                        zflag,
  output logic                        halted,
  input  logic [sel_width(REG_N)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int SEL_W = sel_width(REG_N);

  stage_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] opcode_q, operand_q, mdr_q, res_q;
  logic              tc_q, tz_q, cflag_q, zflag_q, halt_req_q, halted_q;

  logic [4:0]        op;
  logic [SEL_W-1:0]  c_sel, a_sel;
  logic [DATA_W-1:0] r_a, r_c, alu_res, rf_wdata;
  logic              alu_c, rf_we, is_mem, is_alu, is_load;

  assign op      = opcode_q[DATA_W-1 -: 5];
  assign c_sel   = opcode_q[SEL_W-1:0];
  assign a_sel   = operand_q[DATA_W-1 -: SEL_W];
  assign is_mem  = op inside {OP_LD, OP_LDS, OP_ST, OP_STS};
  assign is_load = op inside {OP_LD, OP_LDS};
  assign is_alu  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};

  regfile_p #(.REG_N(REG_N), .DATA_W(DATA_W)) u_rf (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_a_sel_i  (a_sel),
    .rd_a_data_o (r_a),
    .rd_c_sel_i  (c_sel),
    .rd_c_data_o (r_c),
    .rd_d_sel_i  (dbg_sel),
    .rd_d_data_o (dbg_data),
    .we_i        (rf_we),
    .wr_sel_i    (c_sel),
    .wr_data_i   (rf_wdata)
  );

  // ALU result and carry/borrow for the latched instruction.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, r_c} + {1'b0, r_a};
      OP_SUB:  begin alu_res = r_c - r_a; alu_c = (r_c < r_a); end
      OP_AND:  alu_res = r_c & r_a;
      OP_OR:   alu_res = r_c | r_a;
      default: ;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_AWAIT;
    else        state_q <= state_d;
  end

  // Next-stage selection and memory request generation.
  // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    case (state_q)
      S_AWAIT:  if (run) state_d = S_FETCHA;
      S_FETCHA: begin mem_rd = 1'b1; if (mem_ready) state_d = S_FETCHB; end
      S_FETCHB: begin mem_rd = 1'b1; if (mem_ready) state_d = S_EXECA; end
      S_EXECA: begin
        case (op)
          OP_LD:   begin mem_rd = 1'b1; mem_addr = r_a[ADDR_W-1:0]; end
          OP_LDS:  begin mem_rd = 1'b1; mem_addr = operand_q[ADDR_W-1:0]; end
          OP_ST:   begin mem_wr = 1'b1; mem_addr = r_a[ADDR_W-1:0]; mem_wdata = r_c; end
          OP_STS:  begin mem_wr = 1'b1; mem_addr = operand_q[ADDR_W-1:0]; mem_wdata = r_c; end
          default: ;
        endcase
        if (!is_mem || mem_ready) state_d = S_EXECB;
      end
      S_EXECB:  state_d = (op == OP_HLT || halt_req_q || halt) ? S_AWAIT : S_FETCHA;
      default:  state_d = S_AWAIT;
    endcase
  end

  // Register-file write selection: immediate/move in EXECA, load/ALU results in EXECB.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = r_a;
    if (state_q == S_EXECA) begin
      if (op == OP_LDI)      begin rf_we = 1'b1; rf_wdata = operand_q; end
      else if (op == OP_MOV) begin rf_we = 1'b1; rf_wdata = r_a; end
    end else if (state_q == S_EXECB) begin
      if (is_load)     begin rf_we = 1'b1; rf_wdata = mdr_q; end
      else if (is_alu) begin rf_we = 1'b1; rf_wdata = res_q; end
    end
  end

  // Datapath registers: PC, instruction latches, MDR, ALU temporaries, flags and halt state.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      opcode_q   <= '0;
      operand_q  <= '0;
      mdr_q      <= '0;
      res_q      <= '0;
      tc_q       <= 1'b0;
      tz_q       <= 1'b0;
      cflag_q    <= 1'b0;
      zflag_q    <= 1'b0;
      halt_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (halt) halt_req_q <= 1'b1;
      case (state_q)
        S_AWAIT:  if (run) halted_q <= 1'b0;
        S_FETCHA: if (mem_ready) begin opcode_q <= mem_rdata; pc_q <= pc_q + ADDR_W'(1); end
        S_FETCHB: if (mem_ready) begin operand_q <= mem_rdata; pc_q <= pc_q + ADDR_W'(1); end
        S_EXECA: begin
          if (is_load && mem_ready) mdr_q <= mem_rdata;
          if (is_alu) begin
            res_q <= alu_res;
            tc_q  <= alu_c;
            tz_q  <= (alu_res == '0);
          end
        end
        S_EXECB: begin
          if (is_alu) begin cflag_q <= tc_q; zflag_q <= tz_q; end
          case (op)
            OP_JMP:  pc_q <= operand_q[ADDR_W-1:0];
            OP_JZ:   if (zflag_q) pc_q <= operand_q[ADDR_W-1:0];
            OP_JC:   if (cflag_q) pc_q <= operand_q[ADDR_W-1:0];
            default: ;
          endcase
          if (state_d == S_AWAIT) begin
            halted_q   <= 1'b1;
            halt_req_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc      = pc_q;
  assign opcode  = opcode_q;
  assign operand = operand_q;
  assign stage   = state_q;
  assign cflag   = cflag_q;
  assign zflag   = zflag_q;
  assign halted  = halted_q;

endmodule
